niosinst_ci_divider: RTL and testbench

- Multi-cycle Nios II custom-instruction divider: the inverse operation to the CPU's hardware multiply cell.
- Performs 32-bit unsigned/signed divide and remainder with a radix-2 restoring algorithm, one quotient bit per clock.
- Sits on the custom-instruction slave port alongside the CPU.
- Uses the multicycle start/done handshake, gated by clk_en.

---
 rtl/niosinst_ci_divider_if.sv | 33 +++
 rtl/niosinst_ci_divider.sv | 131 +++++++++++++
 tb/tb_niosinst_ci_divider.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/niosinst_ci_divider_if.sv
// -----------------------------------------------------------------------------
// niosinst_ci_divider_if
// Custom-instruction bus between the Nios II CPU (master) and the
// multicycle divider (slave).
//   clk_en : global clock enable; when low the slave holds all state
//   start  : operation request, sampled while clk_en=1
//   dataa  : dividend
//   datab  : divisor
//   n      : function select (0=DIVU, 1=DIV, 2=REMU, 3=REM)
//   result : quotient or remainder, registered
//   done   : one-cycle pulse, result valid in the same cycle
// -----------------------------------------------------------------------------
interface niosinst_ci_divider_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  clk_en;
   logic                  start;
   logic [DATA_WIDTH-1:0] dataa;
   logic [DATA_WIDTH-1:0] datab;
   logic [1:0]            n;
   logic [DATA_WIDTH-1:0] result;
   logic                  done;

   modport slave (
      input  clk_en, start, dataa, datab, n,
      output result, done
   );

   modport master (
      output clk_en, start, dataa, datab, n,
      input  result, done
   );
endinterface

// File: rtl/niosinst_ci_divider.sv
// -----------------------------------------------------------------------------
// niosinst_ci_divider
// Multicycle Nios II custom-instruction divider. Radix-2 restoring division,
// one quotient bit per enabled clock, signed/unsigned divide and remainder.
//   clk     : system clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   ci      : custom-instruction slave port (clk_en, start, dataa, datab, n,
//             result, done)
// Latency from the edge sampling start to the done cycle is DATA_WIDTH+2
// enabled edges (IDLE load, DATA_WIDTH CALC steps, FIX).
// -----------------------------------------------------------------------------
module niosinst_ci_divider #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        reset_n,
   niosinst_ci_divider_if.slave        ci
);
   localparam int CW  = $clog2(DATA_WIDTH);
   localparam int MSB = DATA_WIDTH - 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic [DATA_WIDTH-1:0] quo_q;      // dividend shifts out, quotient shifts in
   logic [DATA_WIDTH-1:0] rem_q;      // partial remainder
   logic [DATA_WIDTH-1:0] dvs_q;      // divisor magnitude
   logic [DATA_WIDTH-1:0] result_q;
   logic                  done_q;
   logic [1:0]            fn_q;
   logic                  sa_q;       // dividend sign
   logic                  sb_q;       // divisor sign
   logic                  div0_q;

   logic [DATA_WIDTH-1:0] a_abs_d, b_abs_d;
   logic                  div0_d;
   logic [DATA_WIDTH:0]   rem_sh;
   logic [DATA_WIDTH+1:0] trial;
   logic [DATA_WIDTH-1:0] rem_d, quo_d;
   logic [DATA_WIDTH-1:0] q_fix, r_fix, fix_d;

   // Operand conditioning at start. With a zero divisor the raw dividend is
   // loaded unmodified: every trial then succeeds, the quotient fills with
   // ones and the remainder ends up as the raw dividend, so no special
   // result path is needed, only the sign fixup bypass below.
   always_comb begin
      div0_d  = (ci.datab == '0);
      a_abs_d = ci.dataa;
      b_abs_d = ci.datab;
      if (ci.n[0] && !div0_d) begin
         if (ci.dataa[MSB]) a_abs_d = -ci.dataa;   // 0x80..0 maps to itself
         if (ci.datab[MSB]) b_abs_d = -ci.datab;
      end
   end

   // One restoring step. The trial is one bit wider than the shifted
   // remainder so its top bit is a clean borrow/sign flag.
   always_comb begin
      rem_sh = {rem_q, quo_q[MSB]};
      trial  = {1'b0, rem_sh} - {2'b00, dvs_q};
      if (!trial[DATA_WIDTH+1]) begin
         rem_d = trial[DATA_WIDTH-1:0];
         quo_d = {quo_q[MSB-1:0], 1'b1};
      end else begin
         rem_d = rem_sh[DATA_WIDTH-1:0];
         quo_d = {quo_q[MSB-1:0], 1'b0};
      end
   end

   // Result selection and sign fixup (quotient negative when signs differ,
   // remainder follows the dividend sign).
   always_comb begin
      q_fix = quo_q;
      r_fix = rem_q;
      if (fn_q[0] && !div0_q) begin
         if (sa_q ^ sb_q) q_fix = -quo_q;
         if (sa_q)        r_fix = -rem_q;
      end
      fix_d = fn_q[1] ? r_fix : q_fix;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         fn_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         div0_q   <= 1'b0;
      end else if (ci.clk_en) begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (ci.start) begin
                  fn_q    <= ci.n;
                  sa_q    <= ci.dataa[MSB];
                  sb_q    <= ci.datab[MSB];
                  div0_q  <= div0_d;
                  quo_q   <= a_abs_d;
                  dvs_q   <= b_abs_d;
                  rem_q   <= '0;
                  cnt_q   <= CW'(DATA_WIDTH - 1);
                  state_q <= CALC;
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               if (cnt_q == '0) state_q <= FIX;
               else             cnt_q   <= cnt_q - CW'(1);
            end
            FIX: begin
               result_q <= fix_d;
               done_q   <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ci.result = result_q;
   assign ci.done   = done_q;

endmodule

// File: tb/tb_niosinst_ci_divider.sv
module tb_niosinst_ci_divider;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   niosinst_ci_divider_if #(.DATA_WIDTH(32)) ci ();

   niosinst_ci_divider #(.DATA_WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ci      (ci)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  fn;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference built from plain language-level division: signed '/' and '%'
   // truncate toward zero, so the remainder carries the dividend's sign.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] fn);
      longint sa, sb, q, r;
      if (b == 32'd0) return fn[1] ? a : 32'hFFFF_FFFF;
      if (!fn[0]) return fn[1] ? (a % b) : (a / b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return fn[1] ? r[31:0] : q[31:0];
   endfunction

   // Runs one operation over a fixed 50-edge window. Edge count c=1 is the
   // edge that samples start. clk_en is dropped for edges stall_at+1 ..
   // stall_at+stall_len; a stray start is raised for edge pulse_at+1.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] fn,
                        input int stall_at, input int stall_len, input int pulse_at,
                        output logic [31:0] res, output int lat, output int nd);
      res = 32'h0;
      lat = -1;
      nd  = 0;
      @(negedge clk);
      ci.dataa  = a;
      ci.datab  = b;
      ci.n      = fn;
      ci.start  = 1'b1;
      ci.clk_en = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(posedge clk);
         #1;
         ci.start  = (c == pulse_at);
         ci.clk_en = !(c >= stall_at && c < stall_at + stall_len);
         @(negedge clk);
         if (ci.done) begin
            nd++;
            if (lat < 0) begin
               lat = c;
               res = ci.result;
            end
         end
      end
      ci.start  = 1'b0;
      ci.clk_en = 1'b1;
   endtask

   vec_t        vecs[12];
   logic [31:0] res;
   int          lat, nd;
   logic [31:0] ra, rb, prev;
   logic [1:0]  rf;

   initial begin
      vecs[0]  = '{32'd100,        32'd7,          2'd0, 32'd14};
      vecs[1]  = '{32'd100,        32'd7,          2'd2, 32'd2};
      vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          2'd1, 32'hFFFF_FFFD};
      vecs[3]  = '{32'hFFFF_FFF9,  32'd2,          2'd3, 32'hFFFF_FFFF};
      vecs[4]  = '{32'd7,          32'hFFFF_FFFE,  2'd1, 32'hFFFF_FFFD};
      vecs[5]  = '{32'd7,          32'hFFFF_FFFE,  2'd3, 32'd1};
      vecs[6]  = '{32'h0000_1234,  32'd0,          2'd0, 32'hFFFF_FFFF};
      vecs[7]  = '{32'hFFFF_FF00,  32'd0,          2'd3, 32'hFFFF_FF00};
      vecs[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  2'd1, 32'h8000_0000};
      vecs[9]  = '{32'h8000_0000,  32'hFFFF_FFFF,  2'd3, 32'd0};
      vecs[10] = '{32'hFFFF_FFFF,  32'd1,          2'd0, 32'hFFFF_FFFF};
      vecs[11] = '{32'hFFFF_FF00,  32'd0,          2'd1, 32'hFFFF_FFFF};

      reset_n   = 1'b0;
      ci.clk_en = 1'b1;
      ci.start  = 1'b0;
      ci.dataa  = '0;
      ci.datab  = '0;
      ci.n      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_result", ci.result, 32'd0);
      chk("reset_done", {31'd0, ci.done}, 32'd0);
      reset_n = 1'b1;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].fn, 0, 0, 0, res, lat, nd);
         chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
         chk($sformatf("vec%0d_latency", i), lat, 34);
         chk($sformatf("vec%0d_done_count", i), nd, 1);
      end

      // clk_en low for 5 edges mid-CALC stretches latency to 39
      do_op(32'd1000, 32'd3, 2'd0, 10, 5, 0, res, lat, nd);
      chk("stall_result", res, 32'd333);
      chk("stall_latency", lat, 39);
      chk("stall_done_count", nd, 1);

      // stray start during CALC is ignored
      do_op(32'hFFFF_FF9C, 32'd9, 2'd3, 0, 0, 6, res, lat, nd);
      chk("ignored_start_result", res, 32'hFFFF_FFFF);
      chk("ignored_start_latency", lat, 34);
      chk("ignored_start_done_count", nd, 1);

      // reset mid-operation: result clears asynchronously, no done follows
      prev = ci.result;
      @(negedge clk);
      ci.dataa = 32'd77; ci.datab = 32'd5; ci.n = 2'd0; ci.start = 1'b1;
      @(posedge clk); #1; ci.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("result_held_during_calc", ci.result, prev);
      repeat (5) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midop_reset_result", ci.result, 32'd0);
      chk("midop_reset_done", {31'd0, ci.done}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ci.done) nd++;
      end
      chk("midop_reset_no_done", nd, 0);
      do_op(32'd50, 32'd5, 2'd0, 0, 0, 0, res, lat, nd);
      chk("post_reset_result", res, 32'd10);
      chk("post_reset_latency", lat, 34);

      // Randomized against the reference model
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         rf = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: rb = 32'($urandom_range(0, 20));
            1: rb = -32'($urandom_range(1, 20));
            2: ra = 32'h8000_0000;
            3: rb = 32'd0;
            default: ;
         endcase
         do_op(ra, rb, rf, 0, 0, 0, res, lat, nd);
         chk($sformatf("rand%0d_a%08h_b%08h_n%0d", i, ra, rb, rf), res, ref_div(ra, rb, rf));
         chk($sformatf("rand%0d_latency", i), lat, 34);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
